imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch/decode path reads.
- Accepts a byte stream (valid/ready) carrying a word count, little-endian 32-bit instructions and an XOR checksum.
- Writes each assembled instruction to consecutive word addresses from 0.
- Holds the core in reset until a load completes with a correct checksum.

Parameters:
- ADDR_W, 11, instruction-memory word-address width; maximum load is 2**ADDR_W words.

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  begin a load; sampled only in IDLE, DONE, ERROR
- rx_valid_i  in  1  byte present on rx_data_i
- rx_data_i  in  8  stream byte
- rx_ready_o  out  1  loader can accept a byte
- imem_we_o  out  1  one-cycle write strobe to instruction memory
- imem_addr_o  out  ADDR_W  word address of the write
- imem_wdata_o  out  32  instruction word
- cpu_rst_no  out  1  core reset, active-low; 0 holds the core in reset
- busy_o  out  1  load in progress
- done_o  out  1  last load succeeded
- err_o  out  2  01 = bad length, 10 = checksum mismatch, 00 = none

Behaviour:
- Reset (async, rst_ni=0):
  - state IDLE, all outputs 0, including cpu_rst_no=0.
  - Word counter, byte counter, length, checksum and assembly registers all 0.
  - Reset mid-load aborts immediately; words already written stay in memory.
- Handshake:
  - A byte transfers on a rising edge with rx_valid_i & rx_ready_o.
  - rx_ready_o=1 only in LEN_LO, LEN_HI, DATA, CHECK; it does not depend on rx_valid_i.
  - The producer holds rx_data_i stable until the transfer.
- State machine:
  - IDLE: start_i -> LEN_LO.
  - LEN_LO: byte -> len[7:0]; -> LEN_HI.
  - LEN_HI: byte -> len[15:8]. If len==0 or len>2**ADDR_W -> ERROR with err_o=01 and no writes; else -> DATA.
  - DATA: the k-th byte of a word (k=0..3) goes to bits [8k+7:8k]. Every data byte is XORed into the checksum.
    - Cycle t = transfer of the 4th byte of word w.
    - Cycle t+1: imem_we_o=1, imem_addr_o=w, imem_wdata_o=assembled word.
    - If w==len-1 -> CHECK at t+1; otherwise stay in DATA.
    - rx_ready_o stays 1 during the write cycle, so the next word's byte may transfer at t+1.
  - CHECK: on the byte transfer, if byte==checksum -> DONE, else -> ERROR with err_o=10. Takes effect the cycle after the transfer.
  - DONE: done_o=1, cpu_rst_no=1, busy_o=0.
  - ERROR: err_o held, cpu_rst_no=0, busy_o=0.
  - DONE or ERROR with start_i=1 -> LEN_LO. On that transition: done_o=0, err_o=00, cpu_rst_no=0, all counters and checksum cleared.
- busy_o=1 exactly in LEN_LO, LEN_HI, DATA, CHECK. start_i is ignored while busy.
- imem_we_o is 0 outside the single write cycles. imem_addr_o and imem_wdata_o hold their last values between writes.
- The word counter is ADDR_W+1 bits wide so len=2**ADDR_W does not wrap; the last address written is 2**ADDR_W-1.
- Timing:
  - Byte throughput is 1 per cycle.
  - Write latency is 1 cycle after the 4th byte.
  - done_o/err_o rise 1 cycle after the checksum byte transfers.

Test Plan:
- Single word, ADDR_W=11:
  - Stimulus: start_i, then bytes 01 00 93 00 50 00 C3 back-to-back.
  - Required: one write addr=0, data=0x00500093; done_o=1, err_o=00, cpu_rst_no=1 one cycle after C3 transfers; rx_ready_o=0 afterwards.
- Two words:
  - Stimulus: 02 00 93 00 50 00 33 81 10 00 61.
  - Required: writes (0, 0x00500093) then (1, 0x00108133), both single-cycle strobes; done_o=1.
- Length error:
  - Stimulus: 00 00 -> err_o=01, no imem_we_o, cpu_rst_no=0.
  - Stimulus with ADDR_W=2: 05 00 -> err_o=01.
  - Stimulus with ADDR_W=2: 04 00 plus 16 data bytes and correct checksum -> writes to addr 0..3, then done_o=1.
- Checksum error:
  - Stimulus: 01 00 93 00 50 00 C4.
  - Required: write (0, 0x00500093) still occurs; err_o=10, done_o=0, cpu_rst_no=0.
  - Then start_i and the correct stream -> err_o clears, done_o=1.
- Backpressure and gaps:
  - Stimulus: single-word stream with rx_valid_i low for 3 cycles between every byte, data held.
  - Required: identical write and result to the first scenario; no byte duplicated or lost.
- Reset mid-load:
  - Stimulus: assert rst_ni=0 after the 2nd data byte of the two-word stream.
  - Required: all outputs 0 asynchronously; no write issued.
  - Then a fresh start_i and the full two-word stream -> done_o=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader for the instruction memory. A byte stream (valid/ready)
//   carries a 16-bit little-endian word count, that many little-endian 32-bit
//   instructions and a final XOR checksum of all instruction bytes. Each
//   assembled instruction is written to consecutive word addresses starting
//   at 0. The core is held in reset until a load finishes with a good checksum.
//
// Ports
//   clk_i         single clock, all state on the rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       begin a load (sampled only in IDLE, DONE, ERROR)
//   rx_valid_i    byte present on rx_data_i
//   rx_data_i     stream byte
//   rx_ready_o    loader can accept a byte
//   imem_we_o     one-cycle write strobe to instruction memory
//   imem_addr_o   word address of the write
//   imem_wdata_o  instruction word
//   cpu_rst_no    core reset, active-low (0 holds the core in reset)
//   busy_o        load in progress
//   done_o        last load succeeded
//   err_o         01 = bad length, 10 = checksum mismatch, 00 = none
//
// ADDR_W is limited to 15 so that the largest legal length fits the 16-bit
// length field.

module imem_loader #(
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } LoaderState;

  // Largest legal word count, one bit wider than the length field so the
  // comparison is exact for every ADDR_W up to 15.
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  LoaderState        r_state;
  LoaderState        w_nextState;

  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_wordCnt;
  logic [1:0]        r_byteCnt;
  logic [7:0]        r_csum;
  logic [23:0]       r_asm;
  logic [1:0]        r_errCode;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_fire;
  logic              w_startOk;
  logic              w_lenBad;
  logic              w_lastWord;
  logic [15:0]       w_lenNew;
  logic [15:0]       w_wordCntExt;

  assign w_fire    = rx_valid_i & rx_ready_o;
  assign w_startOk = start_i & ((r_state == ST_IDLE) ||
                                (r_state == ST_DONE) ||
                                (r_state == ST_ERROR));

  // Full length as it will be once the high byte currently on the bus lands.
  assign w_lenNew = {rx_data_i, r_len[7:0]};
  assign w_lenBad = (w_lenNew == 16'd0) || ({1'b0, w_lenNew} > MAX_LEN);

  // The word counter is one bit wider than the address so a full-memory load
  // does not wrap before the last-word comparison.
  assign w_wordCntExt = 16'(r_wordCnt);
  assign w_lastWord   = (w_wordCntExt == (r_len - 16'd1));

  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Leaving DATA happens on the edge that takes the last
  // byte of the last word, so CHECK is entered together with the final write.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_startOk) w_nextState = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_fire) w_nextState = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_fire) w_nextState = w_lenBad ? ST_ERROR : ST_DATA;
      end
      ST_DATA: begin
        if (w_fire && (r_byteCnt == 2'd3) && w_lastWord) w_nextState = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_fire) w_nextState = (rx_data_i == r_csum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (w_startOk) w_nextState = ST_LEN_LO;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the state alone, so a restart from DONE
  // or ERROR drops done/err/cpu reset on the very cycle LEN_LO is entered.
  always_comb begin
    rx_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    cpu_rst_no = 1'b0;
    err_o      = 2'b00;
    unique case (r_state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      ST_DONE: begin
        done_o     = 1'b1;
        cpu_rst_no = 1'b1;
      end
      ST_ERROR: begin
        err_o = r_errCode;
      end
      default: begin
        rx_ready_o = 1'b0;
      end
    endcase
  end

  // Datapath: length capture, byte assembly, checksum and the registered
  // write port. The write strobe is a pulse; address and data hold between
  // writes. The 4th byte goes straight into the write data, so the assembly
  // register only needs the first three bytes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len     <= '0;
      r_wordCnt <= '0;
      r_byteCnt <= '0;
      r_csum    <= '0;
      r_asm     <= '0;
      r_errCode <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_startOk) begin
        r_len     <= '0;
        r_wordCnt <= '0;
        r_byteCnt <= '0;
        r_csum    <= '0;
        r_asm     <= '0;
        r_errCode <= '0;
      end else begin
        unique case (r_state)
          ST_LEN_LO: begin
            if (w_fire) r_len[7:0] <= rx_data_i;
          end
          ST_LEN_HI: begin
            if (w_fire) begin
              r_len[15:8] <= rx_data_i;
              if (w_lenBad) r_errCode <= 2'b01;
            end
          end
          ST_DATA: begin
            if (w_fire) begin
              r_csum    <= r_csum ^ rx_data_i;
              r_byteCnt <= r_byteCnt + 2'd1;
              unique case (r_byteCnt)
                2'd0: r_asm[7:0]   <= rx_data_i;
                2'd1: r_asm[15:8]  <= rx_data_i;
                2'd2: r_asm[23:16] <= rx_data_i;
                default: begin
                  r_we      <= 1'b1;
                  r_addr    <= r_wordCnt[ADDR_W-1:0];
                  r_wdata   <= {rx_data_i, r_asm};
                  r_wordCnt <= r_wordCnt + (ADDR_W+1)'(1);
                end
              endcase
            end
          end
          ST_CHECK: begin
            if (w_fire && (rx_data_i != r_csum)) r_errCode <= 2'b10;
          end
          default: begin
            r_we <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
